// File: rtl/handshake_pkg.sv
// Shared definitions for the valid/ack handshake master family:
// FSM state encoding and a counter-width helper.
package handshake_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2,
    BACKOFF  = 2'd3
  } state_t;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int count_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hs_fifo.sv
// Synchronous FIFO with a combinational head and an occupancy count that is
// one bit wider than a pointer, so full and empty never alias.
module hs_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign full    = (level == LEVEL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/handshake_master_fifo.sv
// FIFO-fed valid/ack master: drains queued words one at a time with a
// per-attempt ack timeout, bounded retries and an err pulse on drops.
module handshake_master_fifo
  import handshake_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   ack,
  output logic                   valid,
  output logic [DATA_W-1:0]      data,
  output logic                   err,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  localparam int TIMER_W = count_width(TIMEOUT);
  localparam int RETRY_W = count_width(MAX_RETRY);
  localparam bit TIMEOUT_EN = (TIMEOUT > 0);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

  state_t              ps;
  state_t              ns;
  logic [TIMER_W-1:0]  timer;
  logic [TIMER_W-1:0]  timer_nx;
  logic [RETRY_W-1:0]  retry;
  logic [RETRY_W-1:0]  retry_nx;
  logic                valid_nx;
  logic [DATA_W-1:0]   data_nx;
  logic                err_nx;
  logic                pop;
  logic [DATA_W-1:0]   head;
  logic                fifo_full;
  logic                fifo_empty;

  hs_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = ~fifo_full;
  assign busy     = (ps != IDLE) || !fifo_empty;

  // Ack beats a timeout on the same edge; ack is ignored outside WAIT_ACK.
  always_comb begin
    ns       = ps;
    timer_nx = timer;
    retry_nx = retry;
    valid_nx = valid;
    data_nx  = data;
    err_nx   = 1'b0;
    pop      = 1'b0;
    case (ps)
      IDLE: begin
        valid_nx = 1'b0;
        if (!fifo_empty) ns = SEND;
      end
      SEND: begin
        pop      = 1'b1;
        data_nx  = head;
        valid_nx = 1'b1;
        timer_nx = '0;
        retry_nx = '0;
        ns       = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack) begin
          valid_nx = 1'b0;
          ns       = IDLE;
        end else if (TIMEOUT_EN && (timer == TIMER_LAST)) begin
          valid_nx = 1'b0;
          if (retry < RETRY_LAST) begin
            retry_nx = retry + RETRY_W'(1);
            ns       = BACKOFF;
          end else begin
            err_nx = 1'b1;
            ns     = IDLE;
          end
        end else if (TIMEOUT_EN) begin
          timer_nx = timer + TIMER_W'(1);
        end
      end
      BACKOFF: begin
        valid_nx = 1'b1;
        timer_nx = '0;
        ns       = WAIT_ACK;
      end
      default: ns = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ps    <= IDLE;
      timer <= '0;
      retry <= '0;
      valid <= 1'b0;
      data  <= '0;
      err   <= 1'b0;
    end else begin
      ps    <= ns;
      timer <= timer_nx;
      retry <= retry_nx;
      valid <= valid_nx;
      data  <= data_nx;
      err   <= err_nx;
    end
  end

endmodule

// File: tb/tb_handshake_master_fifo.sv
// Bench for handshake_master_fifo: directed scenarios plus random traffic,
// all compared every cycle against a queue-based transfer model.
module tb_handshake_master_fifo;

  localparam int DEPTH     = 4;
  localparam int TIMEOUT   = 4;
  localparam int MAX_RETRY = 2;

  logic       clk;
  logic       rstn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       ack;
  logic       valid;
  logic [7:0] data;
  logic       err;
  logic [2:0] level;
  logic       busy;

  logic       nt_in_valid;
  logic       nt_in_ready;
  logic [7:0] nt_in_data;
  logic       nt_ack;
  logic       nt_valid;
  logic [7:0] nt_data;
  logic       nt_err;
  logic [2:0] nt_level;
  logic       nt_busy;

  int n_vec = 0;
  int n_bad = 0;

  handshake_master_fifo #(
    .DATA_W(8), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .ack(ack), .valid(valid), .data(data), .err(err),
    .level(level), .busy(busy)
  );

  // Second instance exercises the wait-forever mode (TIMEOUT = 0).
  handshake_master_fifo #(
    .DATA_W(8), .DEPTH(DEPTH), .TIMEOUT(0), .MAX_RETRY(3)
  ) dut_nt (
    .clk(clk), .rstn(rstn), .in_valid(nt_in_valid), .in_ready(nt_in_ready),
    .in_data(nt_in_data), .ack(nt_ack), .valid(nt_valid), .data(nt_data),
    .err(nt_err), .level(nt_level), .busy(nt_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: queued words plus the word on the link, its attempt count and
  // how many no-ack cycles the current attempt has seen.
  logic [7:0] q[$];
  logic       m_valid  = 1'b0;
  logic [7:0] m_data   = 8'h00;
  logic       m_err    = 1'b0;
  bit         inflight = 1'b0;
  bit         armed    = 1'b0;
  int         age      = 0;
  int         attempt  = 0;

  task automatic modelReset();
    q.delete();
    m_valid  = 1'b0;
    m_data   = 8'h00;
    m_err    = 1'b0;
    inflight = 1'b0;
    armed    = 1'b0;
    age      = 0;
    attempt  = 0;
  endtask

  task automatic modelEdge(input logic iv, input logic [7:0] id, input logic ak);
    bit do_push;
    if (!rstn) return;
    do_push = iv && (q.size() < DEPTH);
    m_err = 1'b0;
    if (inflight) begin
      if (m_valid) begin
        if (ak) begin
          m_valid  = 1'b0;
          inflight = 1'b0;
        end else begin
          age++;
          if (age == TIMEOUT) begin
            m_valid = 1'b0;
            if (attempt < MAX_RETRY) attempt++;
            else begin
              m_err    = 1'b1;
              inflight = 1'b0;
            end
          end
        end
      end else begin
        m_valid = 1'b1;
        age     = 0;
      end
    end else if (armed) begin
      m_data   = q.pop_front();
      m_valid  = 1'b1;
      age      = 0;
      attempt  = 0;
      inflight = 1'b1;
      armed    = 1'b0;
    end else if (q.size() != 0) begin
      armed = 1'b1;
    end
    if (do_push) q.push_back(id);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [7:0] id, input logic ak);
    @(negedge clk);
    in_valid = iv;
    in_data  = id;
    ack      = ak;
    @(posedge clk);
    modelEdge(iv, id, ak);
    #1;
  endtask

  always @(negedge clk) begin
    checkOutput("valid",    32'(valid),    32'(m_valid));
    checkOutput("data",     32'(data),     32'(m_data));
    checkOutput("err",      32'(err),      32'(m_err));
    checkOutput("level",    32'(level),    32'(q.size()));
    checkOutput("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    checkOutput("busy",     32'(busy),     32'(inflight || armed || q.size() != 0));
  end

  task automatic doMidReset();
    rstn = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_valid",    32'(valid),    32'd0);
    checkOutput("rst_data",     32'(data),     32'd0);
    checkOutput("rst_err",      32'(err),      32'd0);
    checkOutput("rst_level",    32'(level),    32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_busy",     32'(busy),     32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    rstn = 1'b1;
  endtask

  task automatic waitValid(input int max_cycles);
    int n = 0;
    while (!valid && n < max_cycles) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      n++;
    end
    if (!valid) checkOutput("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [18:0] exp_drop;
    logic [7:0]  got[$];
    logic        prev_v;
    int          hi_cnt;
    int          err_seen;
    int          mode;

    rstn        = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    ack         = 1'b0;
    nt_in_valid = 1'b0;
    nt_in_data  = 8'h00;
    nt_ack      = 1'b0;
    #2;
    doMidReset();

    // Single transfer: valid two edges after the push, dropped on ack.
    applyStimulus(1'b1, 8'h3C, 1'b0);
    checkOutput("single_level_after_push", 32'(level), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("single_valid_e1", 32'(valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("single_valid_e2", 32'(valid), 32'd1);
    checkOutput("single_data", 32'(data), 32'h3C);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("single_valid_after_ack", 32'(valid), 32'd0);
    checkOutput("single_level_end", 32'(level), 32'd0);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);

    // Ack while idle does nothing.
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("idle_ack_busy", 32'(busy), 32'd0);
    checkOutput("idle_ack_valid", 32'(valid), 32'd0);

    // Reset while a word is on the link.
    applyStimulus(1'b1, 8'hA5, 1'b0);
    waitValid(10);
    checkOutput("mid_reset_pre_data", 32'(data), 32'hA5);
    doMidReset();
    repeat (5) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("after_reset_no_transfer", 32'(valid), 32'd0);

    // Drop: three attempts of 4, gaps of 1, err on the last drop, next word 2 later.
    exp_drop = 19'b1_0_0_1111_0_1111_0_1111_0_0;
    applyStimulus(1'b1, 8'hD1, 1'b0);
    checkOutput("drop_valid_0", 32'(valid), 32'(exp_drop[0]));
    for (int i = 1; i < 19; i++) begin
      applyStimulus(i == 1, 8'hD2, 1'b0);
      checkOutput($sformatf("drop_valid_%0d", i), 32'(valid), 32'(exp_drop[i]));
      checkOutput($sformatf("drop_err_%0d", i), 32'(err), 32'(i == 16));
    end
    checkOutput("drop_next_data", 32'(data), 32'hD2);
    applyStimulus(1'b0, 8'h00, 1'b1);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);

    // Retry: ack withheld for two attempts, given on the third.
    applyStimulus(1'b1, 8'hB7, 1'b0);
    for (int i = 1; i < 13; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("retry_third_valid", 32'(valid), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("retry_acked_valid", 32'(valid), 32'd0);
    checkOutput("retry_acked_err", 32'(err), 32'd0);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);

    // Ack on the exact timeout edge wins: no backoff re-raise, no err.
    applyStimulus(1'b1, 8'hE4, 1'b0);
    waitValid(10);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("ack_on_timeout_err", 32'(err), 32'd0);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ack_on_timeout_no_retry", 32'(valid), 32'd0);

    // Fill and drain in order.
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    checkOutput("fill_level", 32'(level), 32'd4);
    checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 8'h06, 1'b0);
    checkOutput("fill_refused", 32'(level), 32'd4);
    got.delete();
    if (valid) got.push_back(data);
    prev_v = valid;
    for (int n = 0; n < 60 && !(got.size() == 5 && level == 0 && !valid); n++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      if (valid && !prev_v) got.push_back(data);
      prev_v = valid;
    end
    checkOutput("drain_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < got.size() && i < 5; i++)
      checkOutput($sformatf("drain_order_%0d", i), 32'(got[i]), 32'(i + 1));
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);

    // Random traffic with shifting ack behaviour and occasional resets.
    for (int blk = 0; blk < 12; blk++) begin
      mode = $urandom_range(0, 3);
      for (int c = 0; c < 200; c++) begin
        applyStimulus($urandom_range(0, 9) < 4, 8'($urandom),
                      (mode == 3) || (mode == 2 && $urandom_range(0, 9) < 6) ||
                      (mode == 1 && $urandom_range(0, 9) < 2));
        if ($urandom_range(0, 399) == 0) doMidReset();
      end
    end
    repeat (60) applyStimulus(1'b0, 8'h00, 1'b1);

    // TIMEOUT = 0: valid held for 100 cycles, then acked, never err.
    nt_in_valid = 1'b1;
    nt_in_data  = 8'h77;
    applyStimulus(1'b0, 8'h00, 1'b0);
    nt_in_valid = 1'b0;
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("nt_data", 32'(nt_data), 32'h77);
    hi_cnt   = nt_valid ? 1 : 0;
    err_seen = 0;
    for (int i = 0; i < 99; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      if (nt_valid) hi_cnt++;
      if (nt_err) err_seen++;
    end
    checkOutput("nt_hold_cycles", 32'(hi_cnt), 32'd100);
    checkOutput("nt_no_err", 32'(err_seen), 32'd0);
    nt_ack = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    nt_ack = 1'b0;
    checkOutput("nt_valid_after_ack", 32'(nt_valid), 32'd0);
    checkOutput("nt_err_after_ack", 32'(nt_err), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("nt_level_end", 32'(nt_level), 32'd0);
    checkOutput("nt_busy_end", 32'(nt_busy), 32'd0);
    checkOutput("nt_in_ready_end", 32'(nt_in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
